// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO.
// Frames are start, DATA_BITS data bits LSB first, optional parity, then 1 or 2 stop bits.
// Bit boundaries follow a free-running divider of en_16x pulses. A non-empty FIFO
// chains frames back to back with no idle gap.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en_16x,
  input  logic                               wr_tx,
  input  logic [DATA_BITS-1:0]               wr_data,
  input  logic [1:0]                         parity_mode,
  input  logic                               stop2,
  output logic                               txd,
  output logic                               tbr,
  output logic                               tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_cnt,
  output logic                               ovf
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DivW = $clog2(OVERSAMPLE);

  localparam logic [CntW-1:0] Depth    = CntW'(FIFO_DEPTH);
  localparam logic [DivW-1:0] DivMax   = DivW'(OVERSAMPLE - 1);
  localparam logic [2:0]      LastData = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                 state;
  logic [DivW-1:0]        div_cnt;
  logic                   baud_tick;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PtrW-1:0]        rd_ptr;
  logic [PtrW-1:0]        wr_ptr;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic [DATA_BITS-1:0]   head;
  logic [2:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_en;
  logic                   par_val;
  logic                   stop2_lat;
  logic                   last_stop;

  // Baud tick, FIFO status and the push/pop decisions, all from pre-edge state.
  always_comb begin
    baud_tick  = en_16x && (div_cnt == DivMax);
    fifo_full  = (fifo_cnt == Depth);
    fifo_empty = (fifo_cnt == '0);
    tbr        = !fifo_full;
    push       = wr_tx && !fifo_full;
    last_stop  = stop2_lat ? (bit_cnt == 3'd1) : (bit_cnt == 3'd0);
    // A frame is loaded from idle, or straight out of the last stop bit for zero gap.
    pop        = baud_tick && !fifo_empty &&
                 ((state == StIdle) || ((state == StStop) && last_stop));
    head       = mem[rd_ptr];
  end

  // Free-running oversample divider; runs in idle so start bits stay bit-aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (en_16x) begin
      div_cnt <= (div_cnt == DivMax) ? '0 : div_cnt + 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      // A pop in the same cycle does not rescue a write seen while full.
      ovf <= wr_tx && fifo_full;
    end
  end

  // Frame sequencer with registered txd and tx_busy; config is latched at the pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StIdle;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_en    <= 1'b0;
      par_val   <= 1'b0;
      stop2_lat <= 1'b0;
      txd       <= 1'b1;
      tx_busy   <= 1'b0;
    end else if (pop) begin
      state     <= StStart;
      bit_cnt   <= '0;
      shreg     <= head;
      par_en    <= parity_mode[0] ^ parity_mode[1];
      // Mode 10 (odd) inverts the even parity.
      par_val   <= (^head) ^ parity_mode[1];
      stop2_lat <= stop2;
      txd       <= 1'b0;
      tx_busy   <= 1'b1;
    end else if (baud_tick) begin
      unique case (state)
        StIdle: begin
          txd <= 1'b1;
        end
        StStart: begin
          state   <= StData;
          bit_cnt <= '0;
          txd     <= shreg[0];
          shreg   <= shreg >> 1;
        end
        StData: begin
          if (bit_cnt == LastData) begin
            bit_cnt <= '0;
            if (par_en) begin
              state <= StParity;
              txd   <= par_val;
            end else begin
              state <= StStop;
              txd   <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        StParity: begin
          state   <= StStop;
          bit_cnt <= '0;
          txd     <= 1'b1;
        end
        StStop: begin
          // Last stop bit with a non-empty FIFO is handled by the pop branch.
          if (last_stop) begin
            state   <= StIdle;
            bit_cnt <= '0;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state   <= StIdle;
          txd     <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus pushes expected frames, a monitor
// decodes txd bit by bit (every cycle of every bit) and checks inter-frame gaps.
module tb_uart_tx_fifo;

  typedef struct {
    logic [15:0] bits;  // first transmitted bit in bit 0
    int          len;
    int          per;   // clock cycles per bit
    bit          b2b;   // must start on the cycle the previous frame ended
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, en_b;
  logic       wr_a, wr_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       txd_a, tbr_a, tx_busy_a, ovf_a;
  logic       txd_b, tbr_b, tx_busy_b, ovf_b;
  logic [2:0] fifo_cnt_a, fifo_cnt_b;
  logic       mon_txd;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   abort = 1'b0;
  exp_t sb_q[$];

  uart_tx_fifo dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_16x      (en_a),
    .wr_tx       (wr_a),
    .wr_data     (data_a),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .txd         (txd_a),
    .tbr         (tbr_a),
    .tx_busy     (tx_busy_a),
    .fifo_cnt    (fifo_cnt_a),
    .ovf         (ovf_a)
  );

  uart_tx_fifo #(
    .DATA_BITS  (7),
    .FIFO_DEPTH (4),
    .OVERSAMPLE (8)
  ) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_16x      (en_b),
    .wr_tx       (wr_b),
    .wr_data     (data_b),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .txd         (txd_b),
    .tbr         (tbr_b),
    .tx_busy     (tx_busy_b),
    .fifo_cnt    (fifo_cnt_b),
    .ovf         (ovf_b)
  );

  // Only one DUT transmits at a time; the other idles high.
  assign mon_txd = txd_a & txd_b;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_frame(input string nm, input logic [15:0] bits, input int len,
                              input int per, input bit b2b);
    exp_t e;
    e.bits = bits;
    e.len  = len;
    e.per  = per;
    e.b2b  = b2b;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic write_a(input logic [7:0] d);
    data_a = d;
    wr_a   = 1'b1;
    step(1);
    wr_a   = 1'b0;
  endtask

  task automatic wait_busy(input string nm);
    int t = 0;
    while (tx_busy_a !== 1'b1 && t < 400) begin
      step(1);
      t++;
    end
    chk(nm, tx_busy_a, 1);
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while ((sb_q.size() != 0 || tx_busy_a || tx_busy_b) && t < 4000) begin
      step(1);
      t++;
    end
    chk({nm, "_queue"}, sb_q.size(), 0);
    chk({nm, "_idle"}, {tx_busy_a, tx_busy_b}, 0);
  endtask

  // en_16x for the narrow instance: one pulse every third cycle.
  initial begin : gen_en_b
    int k;
    k    = 0;
    en_b = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      k    = (k == 2) ? 0 : k + 1;
      en_b = (k == 2);
    end
  end

  // Monitor: pops an expected frame on each start bit and checks every cycle.
  initial begin : monitor
    exp_t e;
    int   last_end;
    int   start;
    bit   ab;
    bit   ok;
    logic got;
    last_end = -1;
    forever begin
      @(negedge clk);
      if (!abort && mon_txd === 1'b0) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: txd low with no frame queued (cycle %0d)", cyc);
          while (mon_txd === 1'b0 && !abort) @(negedge clk);
        end else begin
          e     = sb_q.pop_front();
          start = cyc;
          ab    = 1'b0;
          if (e.b2b) chk({e.name, "_gap"}, start, last_end);
          for (int i = 0; i < e.len && !ab; i++) begin
            ok  = 1'b1;
            got = e.bits[i];
            for (int c = 0; c < e.per && !ab; c++) begin
              if (i != 0 || c != 0) @(negedge clk);
              if (abort) ab = 1'b1;
              else if (mon_txd !== e.bits[i] && ok) begin
                ok  = 1'b0;
                got = mon_txd;
              end
            end
            if (!ab) chk($sformatf("%s_bit%0d", e.name, i), got, e.bits[i]);
          end
          if (!ab) last_end = start + e.len * e.per;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n       = 1'b0;
    en_a        = 1'b1;
    wr_a        = 1'b0;
    wr_b        = 1'b0;
    data_a      = '0;
    data_b      = '0;
    parity_mode = 2'b00;
    stop2       = 1'b0;
    step(3);

    // Reset state.
    chk("rst_txd", txd_a, 1);
    chk("rst_tbr", tbr_a, 1);
    chk("rst_busy", tx_busy_a, 0);
    chk("rst_cnt", fifo_cnt_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_b_txd", txd_b, 1);
    chk("rst_b_status", {tbr_b, tx_busy_b, ovf_b, fifo_cnt_b}, 6'b100000);
    rst_n = 1'b1;

    // Basic frame 0xA5, no parity, one stop.
    expect_frame("a5", {1'b1, 8'hA5, 1'b0}, 10, 16, 1'b0);
    write_a(8'hA5);
    chk("a5_cnt", fifo_cnt_a, 1);
    wait_busy("a5_busy");
    wait_drain("a5");

    // Even then odd parity on 0x07; each latched at its own pop.
    parity_mode = 2'b01;
    expect_frame("par_even", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 16, 1'b0);
    write_a(8'h07);
    wait_busy("par_busy");
    parity_mode = 2'b10;
    expect_frame("par_odd", {1'b1, 1'b0, 8'h07, 1'b0}, 11, 16, 1'b1);
    write_a(8'h07);
    wait_drain("par");
    parity_mode = 2'b00;

    // Overflow with divider frozen, then four back-to-back frames.
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_a = 8'(17 * (i + 1));
      wr_a   = 1'b1;
      step(1);
      if (i < 4) chk($sformatf("fill_cnt%0d", i), fifo_cnt_a, i + 1);
      else chk("ovf_pulse", ovf_a, 1);
    end
    wr_a = 1'b0;
    chk("full_cnt", fifo_cnt_a, 4);
    chk("full_tbr", tbr_a, 0);
    step(1);
    chk("ovf_one_cycle", ovf_a, 0);
    chk("full_cnt_hold", fifo_cnt_a, 4);
    expect_frame("b2b_11", {1'b1, 8'h11, 1'b0}, 10, 16, 1'b0);
    expect_frame("b2b_22", {1'b1, 8'h22, 1'b0}, 10, 16, 1'b1);
    expect_frame("b2b_33", {1'b1, 8'h33, 1'b0}, 10, 16, 1'b1);
    expect_frame("b2b_44", {1'b1, 8'h44, 1'b0}, 10, 16, 1'b1);
    en_a = 1'b1;
    wait_drain("b2b");

    // Narrow instance: 7 data bits, two stops, 24 cycles per bit.
    stop2 = 1'b1;
    expect_frame("narrow", {2'b11, 7'h55, 1'b0}, 10, 24, 1'b0);
    data_b = 7'h55;
    wr_b   = 1'b1;
    step(1);
    wr_b   = 1'b0;
    wait_drain("narrow");
    stop2 = 1'b0;

    // Parity switched mid-frame only affects the next popped frame.
    expect_frame("cfg_nopar", {1'b1, 8'h3C, 1'b0}, 10, 16, 1'b0);
    write_a(8'h3C);
    wait_busy("cfg_busy");
    expect_frame("cfg_par", {1'b1, 1'b1, 8'h01, 1'b0}, 11, 16, 1'b1);
    write_a(8'h01);
    step(40);
    parity_mode = 2'b01;
    wait_drain("cfg");
    parity_mode = 2'b00;

    // Reset during data bit 3 of 0xF0 with two more words queued.
    expect_frame("rst_f0", {1'b1, 8'hF0, 1'b0}, 10, 16, 1'b0);
    write_a(8'hF0);
    write_a(8'h0F);
    write_a(8'h33);
    wait_busy("rst_busy");
    step(70);
    chk("mid_bit3", txd_a, 0);
    chk("mid_cnt", fifo_cnt_a, 2);
    abort = 1'b1;
    rst_n = 1'b0;
    en_a  = 1'b0;
    step(1);
    chk("midrst_txd", txd_a, 1);
    chk("midrst_cnt", fifo_cnt_a, 0);
    chk("midrst_busy", tx_busy_a, 0);
    rst_n = 1'b1;
    sb_q.delete();
    abort = 1'b0;

    // Divider held at 0: the 16th enabled edge is the first tick and pops.
    write_a(8'h5A);
    write_a(8'hC3);
    chk("sim_cnt_pre", fifo_cnt_a, 2);
    expect_frame("sim_5a", {1'b1, 8'h5A, 1'b0}, 10, 16, 1'b0);
    expect_frame("sim_c3", {1'b1, 8'hC3, 1'b0}, 10, 16, 1'b1);
    expect_frame("sim_96", {1'b1, 8'h96, 1'b0}, 10, 16, 1'b1);
    en_a = 1'b1;
    step(15);
    chk("sim_idle", tx_busy_a, 0);
    write_a(8'h96);
    chk("sim_cnt_post", fifo_cnt_a, 2);
    chk("sim_busy", tx_busy_a, 1);
    wait_drain("sim");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
